// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one memory port between two masters,
//            routing tagged read responses back via an owner FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 30
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          a_read,
    input  logic          a_write,
    input  logic [AW-1:0] a_address,
    input  logic [31:0]   a_writedata,
    input  logic [3:0]    a_writedatamask,
    input  logic [1:0]    a_id,
    output logic          a_waitrequest,
    output logic [31:0]   a_readdata,
    output logic [1:0]    a_readdataid,
    input  logic          b_read,
    input  logic          b_write,
    input  logic [AW-1:0] b_address,
    input  logic [31:0]   b_writedata,
    input  logic [3:0]    b_writedatamask,
    input  logic [1:0]    b_id,
    output logic          b_waitrequest,
    output logic [31:0]   b_readdata,
    output logic [1:0]    b_readdataid,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_writedata,
    output logic [3:0]    mem_writedatamask,
    output logic [1:0]    mem_id,
    input  logic          mem_waitrequest,
    input  logic [31:0]   mem_readdata,
    input  logic [1:0]    mem_readdataid,
    output logic          err_orphan
);

    localparam int                 c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w+1)'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic                 r_last;       // 0 = A, 1 = B
    logic                 r_lock;
    logic                 r_lock_sel;
    logic [DEPTH-1:0]     r_owner;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 r_err_orphan;

    logic w_a_req;
    logic w_b_req;
    logic w_gnt_valid;
    logic w_gnt_b;
    logic w_sel_read;
    logic w_sel_write;
    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_resp;
    logic w_pop;
    logic w_head;

    assign w_a_req = a_read | a_write;
    assign w_b_req = b_read | b_write;

    // Gating with rst keeps the memory port quiet while reset is held.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_b     = 1'b0;
        if (rst) begin
            if (r_lock && (r_lock_sel ? w_b_req : w_a_req)) begin
                w_gnt_valid = 1'b1;
                w_gnt_b     = r_lock_sel;
            end else if (w_a_req && w_b_req) begin
                w_gnt_valid = 1'b1;
                w_gnt_b     = ~r_last;
            end else if (w_a_req) begin
                w_gnt_valid = 1'b1;
            end else if (w_b_req) begin
                w_gnt_valid = 1'b1;
                w_gnt_b     = 1'b1;
            end
        end
    end

    assign w_sel_read  = w_gnt_b ? b_read  : a_read;
    assign w_sel_write = w_gnt_b ? b_write : a_write;
    assign w_full      = (r_count == c_full);
    assign w_empty     = (r_count == '0);

    // Full is judged on pre-pop occupancy, so a popping full FIFO still blocks.
    assign mem_read    = w_gnt_valid & w_sel_read & ~w_full;
    assign mem_write   = w_gnt_valid & w_sel_write;
    assign w_accept    = (mem_read | mem_write) & ~mem_waitrequest;
    assign w_push      = w_accept & w_sel_read;

    assign mem_address       = w_gnt_b ? b_address       : a_address;
    assign mem_writedata     = w_gnt_b ? b_writedata     : a_writedata;
    assign mem_writedatamask = w_gnt_b ? b_writedatamask : a_writedatamask;
    assign mem_id            = w_gnt_b ? b_id            : a_id;

    assign a_waitrequest = ~(w_accept & ~w_gnt_b);
    assign b_waitrequest = ~(w_accept &  w_gnt_b);

    assign w_resp = |mem_readdataid;
    assign w_pop  = w_resp & ~w_empty;
    assign w_head = r_owner[r_rd_ptr];

    assign a_readdata   = mem_readdata;
    assign b_readdata   = mem_readdata;
    assign a_readdataid = (w_pop && !w_head) ? mem_readdataid : 2'b00;
    assign b_readdataid = (w_pop &&  w_head) ? mem_readdataid : 2'b00;
    assign err_orphan   = r_err_orphan;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_last       <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_sel   <= 1'b0;
            r_owner      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last <= w_gnt_b;
                r_lock <= 1'b0;
            end else if (w_gnt_valid) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_gnt_b;
            end else begin
                r_lock <= 1'b0;
            end

            if (w_push) begin
                r_owner[r_wr_ptr] <= w_gnt_b;
                r_wr_ptr          <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= r_count + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);

            if (w_resp && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding reads tracked, power of two, 2..16.
REQ-002 Parameter AW, default 30: word-address width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clock  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_read, a_write  in  1 each  master A (CPU) request strobes.
- a_address  in  AW  master A address.
- a_writedata  in  32  master A write data.
- a_writedatamask  in  4  master A byte enables.
- a_id  in  2  master A read tag; nonzero when a_read.
- a_waitrequest  out  1  master A request not accepted this cycle.
- a_readdata  out  32  read data to A.
- a_readdataid  out  2  A response tag; 0 = no response.
- b_read, b_write, b_address, b_writedata, b_writedatamask, b_id, b_waitrequest, b_readdata, b_readdataid: same widths and meanings for master B (DMA/display).
- mem_read, mem_write  out  1 each  strobes to the shared memory.
- mem_address  out  AW; mem_writedata  out  32; mem_writedatamask  out  4; mem_id  out  2.
- mem_waitrequest  in  1  memory stall.
- mem_readdata  in  32; mem_readdataid  in  2  memory response; nonzero = valid.
- err_orphan  out  1  sticky: response arrived with no outstanding read.

Function
REQ-005 A master requests when its read or write is 1; read and write both 1 is illegal and is not checked.
REQ-006 Accept: the granted request completes in the cycle where the arbiter drives it to memory with mem_waitrequest=0 and the request is not blocked by REQ-011.
REQ-007 Arbitration SHALL be round-robin: register last (reset A) holds the last accepted master; with both requesting and unlocked, grant the master other than last; with one requesting, grant it.
REQ-008 Lock: if a granted request is presented but not accepted, a lock register SHALL hold the grant for the next cycle; lock clears on accept.
REQ-009 The granted master's address, writedata, mask, id and strobes SHALL pass combinationally to mem_*; with no grant, mem_read=mem_write=0 and other mem_* outputs are don't-care.
REQ-010 Waitrequest: the granted master's waitrequest = ~accept; the non-granted master's waitrequest = 1; an idle master's waitrequest = 1.
REQ-011 Owner FIFO (DEPTH entries, 1 bit each: 0=A, 1=B): push the owner on every accepted read. When the FIFO is full, a granted read SHALL drive mem_read=0 and hold waitrequest=1; writes are unaffected.
REQ-012 Response: when mem_readdataid!=0, pop the FIFO head, route mem_readdataid to that owner's readdataid, and drive the other master's readdataid=0. mem_readdata SHALL be broadcast to both readdata outputs.
REQ-013 A push and a pop in the same cycle SHALL keep occupancy unchanged, including at full. Full is evaluated on occupancy before the pop, so a read is blocked in the cycle a full FIFO pops.
REQ-014 Response latency through the arbiter SHALL be zero cycles (combinational).
REQ-015 A response with the FIFO empty SHALL set err_orphan, route to neither master (both readdataid=0), and leave the pointers unchanged.
REQ-016 Pointers SHALL wrap modulo DEPTH; occupancy uses a log2(DEPTH)+1-bit counter.
REQ-017 Writes SHALL carry no response and push nothing.

Reset
REQ-018 Asserting rst SHALL asynchronously force: last=A, lock=0, FIFO pointers and count=0, err_orphan=0.
REQ-019 During reset, mem_read=0, mem_write=0, a_waitrequest=b_waitrequest=1, and a_readdataid=b_readdataid=0.
REQ-020 Outstanding reads are discarded by reset; responses arriving after release set err_orphan.
REQ-021 Reset deassertion is synchronized externally; the first grant occurs on the first clock edge after release.

Verification
REQ-022 A and B both read continuously, mem_waitrequest=0: accepts alternate B,A,B,A... starting with B; each master's waitrequest=0 on alternate cycles.
REQ-023 A write granted while mem_waitrequest=1 for 3 cycles, B requesting throughout: A is held for 3 cycles, accepted in cycle 4, then B is granted; mem_* stable during the stall.
REQ-024 DEPTH=4, four A reads accepted with no responses, fifth read presented: mem_read=0 and a_waitrequest=1. A response arriving in the same cycle still blocks that cycle; the fifth read is accepted next cycle.
REQ-025 A read id=1 accepted, then B read id=2 accepted; responses id 1 then 2: a_readdataid=1 then b_readdataid=2; the other master sees 0 each cycle.
REQ-026 FIFO empty, mem_readdataid=3 injected: err_orphan=1 and stays 1; both readdataid=0. rst asserted mid-stall: mem_read drops immediately and err_orphan=0.
